// File: rtl/bit_serial_adder.sv
// bit_serial_adder
// LSB-first sequential adder built around one external, purely combinational
// full-adder cell. Each RUN cycle presents one operand bit pair plus the
// registered carry on fa_*, then captures the cell's sum/carry at the next edge.
// {carry, sum} = a + b + cin after WIDTH cycles of RUN.
//
// Handshake: start is a request sampled only while busy=0 (IDLE or DONE);
// a request seen while busy=1 is dropped, not queued, and never touches the
// captured operands. done is a one-cycle pulse; sum/carry hold until the next
// accepted start, which clears them on the accepting edge.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_c_reg;
  logic [WIDTH-1:0] r_sum_sh;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;
  logic             w_run;

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_bit_cnt == CW'(WIDTH - 1));

  // Shift the cell's sum bit in at the MSB; written this way so WIDTH=1 needs no slice.
  always_comb begin
    w_sum_next            = r_sum_sh >> 1;
    w_sum_next[WIDTH-1]   = fa_sum;
  end

  assign fa_a      = w_run ? r_a_sh[0] : 1'b0;
  assign fa_b      = w_run ? r_b_sh[0] : 1'b0;
  assign fa_cin    = w_run ? r_c_reg   : 1'b0;
  assign busy      = w_run;
  assign done      = (r_state == S_DONE);
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign dbg_state = r_state;

  // Control FSM plus datapath: launch, per-bit shift/capture, and result latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_c_reg   <= 1'b0;
      r_sum_sh  <= '0;
      r_bit_cnt <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_a_sh    <= r_a_sh >> 1;
          r_b_sh    <= r_b_sh >> 1;
          r_sum_sh  <= w_sum_next;
          r_c_reg   <= fa_carry;
          r_bit_cnt <= r_bit_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_sum   <= w_sum_next;
            r_carry <= fa_carry;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          if (start) begin
            r_state   <= S_RUN;
            r_a_sh    <= a;
            r_b_sh    <= b;
            r_c_reg   <= cin;
            r_sum_sh  <= '0;
            r_bit_cnt <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Sequential LSB-first adder that computes a WIDTH-bit sum using a single external full-adder cell. It sits directly upstream and downstream of that cell. Each cycle it drives one operand bit pair plus the registered carry into the cell, then captures the cell's sum and carry back. Used where area matters more than latency; the full-adder cell itself stays purely combinational.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..64.

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request new addition; sampled only when busy=0
- a  in  WIDTH  operand A; captured on accepted start
- b  in  WIDTH  operand B; captured on accepted start
- cin  in  1  carry-in; captured on accepted start
- fa_a  out  1  bit to full-adder input a
- fa_b  out  1  bit to full-adder input b
- fa_cin  out  1  registered carry to full-adder input cin
- fa_sum  in  1  full-adder sum output
- fa_carry  in  1  full-adder carry output
- busy  out  1  high while an addition is in progress
- done  out  1  one-cycle pulse when sum/carry become valid
- sum  out  WIDTH  result, held until next accepted start
- carry  out  1  final carry-out, held with sum

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: processing bits.
  - DONE: one-cycle result-valid state.
- IDLE or DONE, start=1 → RUN. On that edge:
  - a_sh←a, b_sh←b, c_reg←cin.
  - sum_sh←0, bit_cnt←0.
  - sum and carry outputs are cleared.
- Start is ignored while in RUN. It is neither queued nor allowed to disturb the operands.
- Combinational outputs in RUN: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=c_reg.
- Combinational outputs in IDLE/DONE: fa_a=fa_b=fa_cin=0.
- RUN, each edge:
  - a_sh, b_sh shift right by one.
  - sum_sh shifts right with fa_sum entering at bit WIDTH-1.
  - c_reg←fa_carry.
  - bit_cnt increments.
- When bit_cnt=WIDTH-1 at the edge, the final bit is processed and the state goes to DONE.
  - On that edge, sum output ← final sum_sh value (fa_sum in the MSB) and carry output ← fa_carry.
- DONE: done=1 for exactly that cycle, then IDLE (or RUN if start=1).
- busy=1 exactly in RUN.
- Arithmetic: {carry,sum} = a + b + cin, a (WIDTH+1)-bit result. No wrap other than the natural carry-out.
- bit_cnt width is clog2(WIDTH)+1 bits. WIDTH=1 is legal: RUN lasts one cycle.
- Reset (rst_n=0 at an edge), including mid-RUN:
  - state←IDLE.
  - All registers cleared; the operation in progress is discarded and no done pulse is produced.

## Timing
- Reset values: busy=0, done=0, sum=0, carry=0, fa_a=fa_b=fa_cin=0.
- Start accepted at edge T0. busy is high from T0 to T(WIDTH), i.e. for WIDTH cycles.
- Bit i is presented on fa_* during the cycle after edge T(i) and captured at edge T(i+1).
- sum/carry update and done rises at edge T(WIDTH). Latency from accepted start to done is WIDTH cycles.
- Back-to-back: start held high through DONE re-launches at T(WIDTH+1). Throughput is one result per WIDTH+1 cycles.
- The full-adder path is fa_* → external cell → fa_sum/fa_carry → registers, and must close in one clk period.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0 → sum=0x96, carry=0.
  - done pulses exactly 8 cycles after start and is high for one cycle.
  - busy is high for 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, carry=1. Also a=0xFF, b=0x00, cin=1 → sum=0x00, carry=1.
- Start pulsed again at cycles 3 and 5 of a RUN with a=0x12, b=0x34 → the pending result is still 0x46, carry=0, and no extra done pulse appears.
- rst_n=0 for one cycle during bit 4 of an addition → next cycle busy=0, sum=0, carry=0, fa_*=0; no done pulse follows.
- Start held high continuously with operands changed each launch → one done every 9 cycles, each result correct.
- Randomized run (≥1000 cases) with WIDTH=1, 8 and 13 against the reference {carry,sum}=a+b+cin.
